// File: rtl/fsm_count_checker.sv
// Monitors a free-running binary counter: locks after LOCK_COUNT correct increments,
// then pulses err on every broken step and keeps a saturating error count.
module fsm_count_checker #(
    parameter int WIDTH      = 2,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 count_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected_out,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     last_q, last_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [3:0]           good_q, good_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;

    logic                 match;
    logic [3:0]           good_inc;

    assign match    = (count_in == last_q + WIDTH'(1));
    assign good_inc = good_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        exp_d    = exp_q;
        good_d   = good_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;

        if (clear) begin
            // last_value and expected_out are held; they are don't-care until the next sample
            state_d  = IDLE;
            locked_d = 1'b0;
            errcnt_d = '0;
            good_d   = '0;
        end else if (count_valid) begin
            last_d = count_in;
            exp_d  = count_in + WIDTH'(1);
            case (state_q)
                IDLE: begin
                    good_d  = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == 4'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        state_d  = ACQ;
                        if (errcnt_q != '1) errcnt_d = errcnt_q + ERR_CNT_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            endcase
        end else if (state_q != IDLE && state_q != ACQ && state_q != LOCKED) begin
            // Illegal encodings recover on any edge, sample or not
            state_d  = IDLE;
            locked_d = 1'b0;
            good_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= '0;
            exp_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign locked       = locked_q;
    assign err          = err_q;
    assign err_count    = errcnt_q;
    assign expected_out = exp_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fsm_count_checker.sv
// Directed bench for fsm_count_checker; a second instance with ERR_CNT_W=2 covers saturation.
module tb_fsm_count_checker;

    // Handshake: count_valid qualifies count_in for one rising edge; there is no ready,
    // the checker accepts every qualified sample.

    logic       clk;
    logic       reset;
    logic [1:0] count_in;
    logic       count_valid;
    logic       clear;

    logic       locked, err;
    logic [7:0] err_count;
    logic [1:0] expected_out, dbg_state;

    logic       locked2, err2;
    logic [1:0] err_count2;
    logic [1:0] expected_out2, dbg_state2;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    fsm_count_checker #(.WIDTH(2), .LOCK_COUNT(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .clear(clear), .locked(locked), .err(err), .err_count(err_count),
        .expected_out(expected_out), .dbg_state_o(dbg_state)
    );

    fsm_count_checker #(.WIDTH(2), .LOCK_COUNT(2), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .clear(clear), .locked(locked2), .err(err2), .err_count(err_count2),
        .expected_out(expected_out2), .dbg_state_o(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive_sample(input logic [1:0] v);
        count_in    = v;
        count_valid = 1'b1;
        @(posedge clk);
        #1;
        count_valid = 1'b0;
    endtask

    task automatic drive_idle(input int n);
        count_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; count_in = '0; count_valid = 1'b0; clear = 1'b0;
        #12;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        total++; if (expected_out !== 2'd0) begin bad++; $display("FAIL reset_expected got=%0d want=0", expected_out); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_lock();
        drive_sample(2'd0);
        total++; if (expected_out !== 2'd1 || locked !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL lock_first exp=%0d locked=%0b err=%0b want 1/0/0", expected_out, locked, err); end
        drive_sample(2'd1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%0b want=0", locked); end
        drive_sample(2'd2);
        total++; if (locked !== 1'b1 || expected_out !== 2'd3) begin
            bad++; $display("FAIL lock_acquire locked=%0b exp=%0d want 1/3", locked, expected_out); end
        drive_sample(2'd3);
        drive_sample(2'd0);
        total++; if (locked !== 1'b1 || err !== 1'b0 || expected_out !== 2'd1) begin
            bad++; $display("FAIL lock_wrap locked=%0b err=%0b exp=%0d want 1/0/1", locked, err, expected_out); end
        drive_sample(2'd1);
        total++; if (locked !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL lock_hold locked=%0b err=%0b want 1/0", locked, err); end
    endtask

    task automatic test_mismatch();
        drive_sample(2'd2);
        drive_sample(2'd0);
        total++; if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected_out !== 2'd1) begin
            bad++; $display("FAIL mismatch_err err=%0b cnt=%0d locked=%0b exp=%0d want 1/1/0/1",
                            err, err_count, locked, expected_out); end
        drive_sample(2'd1);
        total++; if (err !== 1'b0 || locked !== 1'b0) begin
            bad++; $display("FAIL mismatch_pulse err=%0b locked=%0b want 0/0", err, locked); end
        drive_sample(2'd2);
        total++; if (locked !== 1'b1 || err_count !== 8'd1) begin
            bad++; $display("FAIL mismatch_relock locked=%0b cnt=%0d want 1/1", locked, err_count); end
    endtask

    task automatic test_gaps();
        drive_clear();
        total++; if (locked !== 1'b0 || err_count !== 8'd0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL gaps_clear locked=%0b cnt=%0d st=%0d want 0/0/0", locked, err_count, dbg_state); end
        drive_sample(2'd0);
        for (int i = 0; i < 5; i++) begin
            drive_idle(1);
            total++; if (err !== 1'b0 || locked !== 1'b0 || expected_out !== 2'd1) begin
                bad++; $display("FAIL gaps_hold1 i=%0d err=%0b locked=%0b exp=%0d want 0/0/1",
                                i, err, locked, expected_out); end
        end
        drive_sample(2'd1);
        for (int i = 0; i < 3; i++) begin
            drive_idle(1);
            total++; if (err !== 1'b0 || locked !== 1'b0 || expected_out !== 2'd2) begin
                bad++; $display("FAIL gaps_hold2 i=%0d err=%0b locked=%0b exp=%0d want 0/0/2",
                                i, err, locked, expected_out); end
        end
        drive_sample(2'd2);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL gaps_lock got=%0b want=1", locked); end
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        drive_clear();
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive_sample(2'd0);
        for (int i = 0; i < 5; i++) begin
            drive_sample(2'd1);
            drive_sample(2'd2);
            total++; if (locked2 !== 1'b1) begin bad++; $display("FAIL sat_relock i=%0d got=%0b want=1", i, locked2); end
            drive_sample(2'd0);
            want = exp_q.pop_front();
            total++; if (err_count2 !== want || err2 !== 1'b1) begin
                bad++; $display("FAIL sat_count i=%0d cnt=%0d err=%0b want %0d/1", i, err_count2, err2, want); end
            total++; if (err_count !== 8'(i + 1)) begin
                bad++; $display("FAIL sat_wide i=%0d got=%0d want=%0d", i, err_count, i + 1); end
        end
    endtask

    task automatic test_clear();
        drive_clear();
        drive_sample(2'd0);
        for (int i = 0; i < 2; i++) begin
            drive_sample(2'd1);
            drive_sample(2'd2);
            drive_sample(2'd0);
        end
        drive_sample(2'd1);
        drive_sample(2'd2);
        total++; if (locked !== 1'b1 || err_count !== 8'd2) begin
            bad++; $display("FAIL clear_setup locked=%0b cnt=%0d want 1/2", locked, err_count); end
        clear = 1'b1;
        drive_sample(2'd3);
        clear = 1'b0;
        total++; if (locked !== 1'b0 || err_count !== 8'd0 || dbg_state !== 2'd0 || err !== 1'b0) begin
            bad++; $display("FAIL clear_wins locked=%0b cnt=%0d st=%0d err=%0b want 0/0/0/0",
                            locked, err_count, dbg_state, err); end
        drive_sample(2'd3);
        total++; if (err !== 1'b0 || expected_out !== 2'd0 || locked !== 1'b0 || dbg_state !== 2'd1) begin
            bad++; $display("FAIL clear_after err=%0b exp=%0d locked=%0b st=%0d want 0/0/0/1",
                            err, expected_out, locked, dbg_state); end
    endtask

    task automatic test_reset_mid();
        drive_clear();
        drive_sample(2'd0);
        drive_sample(2'd1);
        drive_sample(2'd2);
        drive_sample(2'd3);
        #2;
        reset = 1'b0;
        #1;
        total++; if (locked !== 1'b0 || err !== 1'b0 || err_count !== 8'd0 || expected_out !== 2'd0) begin
            bad++; $display("FAIL reset_mid locked=%0b err=%0b cnt=%0d exp=%0d want 0/0/0/0",
                            locked, err, err_count, expected_out); end
        @(posedge clk); #1;
        reset = 1'b1;
        drive_sample(2'd2);
        total++; if (expected_out !== 2'd3 || locked !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_release exp=%0d locked=%0b err=%0b want 3/0/0", expected_out, locked, err); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mismatch();
        test_gaps();
        test_saturate();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
